// File: rtl/raycast_mem_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone master between the ray
// controller (read/write) and N_CORES read-only raycast core ports.
module raycast_mem_arbiter #(
   parameter int N_CORES = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                   wb_clk,
   input  logic                   wb_rst_n,
   input  logic [31:0]            ctrl_wb_adr_i,
   input  logic [3:0]             ctrl_wb_sel_i,
   input  logic                   ctrl_wb_we_i,
   input  logic [31:0]            ctrl_wb_dat_i,
   input  logic                   ctrl_wb_cyc_i,
   input  logic                   ctrl_wb_stb_i,
   output logic [31:0]            ctrl_wb_dat_o,
   output logic                   ctrl_wb_ack_o,
   input  logic [32*N_CORES-1:0]  c_wb_adr_i,
   input  logic [N_CORES-1:0]     c_wb_cyc_i,
   input  logic [N_CORES-1:0]     c_wb_stb_i,
   output logic [31:0]            c_wb_dat_o,
   output logic [N_CORES-1:0]     c_wb_ack_o,
   output logic [31:0]            m_wb_adr_o,
   output logic [3:0]             m_wb_sel_o,
   output logic                   m_wb_we_o,
   output logic [31:0]            m_wb_dat_o,
   input  logic [31:0]            m_wb_dat_i,
   output logic                   m_wb_cyc_o,
   output logic                   m_wb_stb_o,
   input  logic                   m_wb_ack_i,
   input  logic                   m_wb_err_i,
   output logic [2:0]             m_wb_cti_o,
   output logic [1:0]             m_wb_bte_o,
   output logic [N_CORES:0]       grant_o,
   output logic [15:0]            err_count_o
);

   localparam int NR = N_CORES + 1;
   localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t      state;
   logic [2:0]  rr;
   logic [2:0]  owner;
   logic [2:0]  win;
   logic        any_req;
   logic [3:0]  cand;
   logic [7:0]  req;
   logic [31:0] win_adr;
   logic [31:0] win_dat;
   logic [3:0]  win_sel;
   logic        win_we;
   logic [31:0] tmo_cnt;
   logic [15:0] err_cnt;
   logic        tmo_hit;
   logic        fail;

   assign m_wb_cti_o  = '0;
   assign m_wb_bte_o  = '0;
   assign err_count_o = err_cnt;

   assign req     = 8'({c_wb_cyc_i & c_wb_stb_i, ctrl_wb_cyc_i & ctrl_wb_stb_i});
   assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
   assign fail    = m_wb_err_i | tmo_hit;

   // Search starts one past the last winner and wraps modulo NR.
   always_comb begin
      any_req = 1'b0;
      win     = '0;
      cand    = '0;
      for (int unsigned i = 1; i <= NR; i++) begin
         cand = {1'b0, rr} + 4'(i);
         if (cand >= 4'(NR))
            cand = cand - 4'(NR);
         if (!any_req && req[cand[2:0]]) begin
            any_req = 1'b1;
            win     = cand[2:0];
         end
      end
   end

   always_comb begin
      win_adr = ctrl_wb_adr_i;
      win_sel = ctrl_wb_sel_i;
      win_we  = ctrl_wb_we_i;
      win_dat = ctrl_wb_dat_i;
      for (int unsigned k = 0; k < N_CORES; k++) begin
         if (win == 3'(k + 1)) begin
            win_adr = c_wb_adr_i[32*k +: 32];
            win_sel = 4'hF;
            win_we  = 1'b0;
            win_dat = '0;
         end
      end
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state         <= IDLE;
         rr            <= 3'(N_CORES);
         owner         <= '0;
         tmo_cnt       <= '0;
         err_cnt       <= '0;
         m_wb_adr_o    <= '0;
         m_wb_sel_o    <= '0;
         m_wb_we_o     <= 1'b0;
         m_wb_dat_o    <= '0;
         m_wb_cyc_o    <= 1'b0;
         m_wb_stb_o    <= 1'b0;
         grant_o       <= '0;
         ctrl_wb_dat_o <= '0;
         ctrl_wb_ack_o <= 1'b0;
         c_wb_dat_o    <= '0;
         c_wb_ack_o    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner      <= win;
                  rr         <= win;
                  grant_o    <= NR'(1) << win;
                  m_wb_adr_o <= win_adr;
                  m_wb_sel_o <= win_sel;
                  m_wb_we_o  <= win_we;
                  m_wb_dat_o <= win_dat;
                  m_wb_cyc_o <= 1'b1;
                  m_wb_stb_o <= 1'b1;
                  tmo_cnt    <= '0;
                  state      <= BUS;
               end
            end
            BUS: begin
               tmo_cnt <= tmo_cnt + 32'd1;
               if (m_wb_ack_i || fail) begin
                  m_wb_cyc_o <= 1'b0;
                  m_wb_stb_o <= 1'b0;
                  state      <= RESP;
                  if (owner == 3'd0) begin
                     ctrl_wb_ack_o <= 1'b1;
                     ctrl_wb_dat_o <= fail ? 32'h0 : m_wb_dat_i;
                  end else begin
                     c_wb_dat_o <= fail ? 32'h0 : m_wb_dat_i;
                     for (int unsigned k = 0; k < N_CORES; k++)
                        c_wb_ack_o[k] <= (owner == 3'(k + 1));
                  end
                  if (fail && err_cnt != 16'hFFFF)
                     err_cnt <= err_cnt + 16'd1;
               end
            end
            RESP: begin
               ctrl_wb_ack_o <= 1'b0;
               c_wb_ack_o    <= '0;
               grant_o       <= '0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/raycast_mem_arbiter.md
Name: raycast_mem_arbiter

Overview:
- Shares the single downstream Wishbone master between two kinds of requester: the ray controller port (read/write) and N_CORES raycast core ports (single-word, read-only octree fetches).
- Sits between the controller/cores and the external master interface.
- Round-robin arbitration, one outstanding classic transfer at a time, with bus-error and timeout recovery.

Parameters:
- N_CORES, 4, number of core read ports (1..4); requester index 0 = ctrl, 1..N_CORES = core0..core(N_CORES-1).
- TIMEOUT, 1024, max cycles in BUS without ack/err before abort; 0 disables the timeout.

Ports:
- wb_clk  in  1  clock
- wb_rst_n  in  1  asynchronous active-low reset
- ctrl_wb_adr_i  in  32  ctrl address
- ctrl_wb_sel_i  in  4  ctrl byte select
- ctrl_wb_we_i  in  1  ctrl write enable
- ctrl_wb_dat_i  in  32  ctrl write data
- ctrl_wb_cyc_i  in  1  ctrl cycle
- ctrl_wb_stb_i  in  1  ctrl strobe
- ctrl_wb_dat_o  out  32  ctrl read data
- ctrl_wb_ack_o  out  1  ctrl acknowledge
- c_wb_adr_i  in  32*N_CORES  core addresses, core k at bits [32k+31:32k]
- c_wb_cyc_i  in  N_CORES  core cycle
- c_wb_stb_i  in  N_CORES  core strobe
- c_wb_dat_o  out  32  read data, shared by all cores
- c_wb_ack_o  out  N_CORES  per-core acknowledge
- m_wb_adr_o  out  32  downstream address
- m_wb_sel_o  out  4  downstream byte select
- m_wb_we_o  out  1  downstream write enable
- m_wb_dat_o  out  32  downstream write data
- m_wb_dat_i  in  32  downstream read data
- m_wb_cyc_o  out  1  downstream cycle
- m_wb_stb_o  out  1  downstream strobe
- m_wb_ack_i  in  1  downstream acknowledge
- m_wb_err_i  in  1  downstream error
- m_wb_cti_o  out  3  constant 3'b000 (classic)
- m_wb_bte_o  out  2  constant 2'b00
- grant_o  out  N_CORES+1  one-hot current owner
- err_count_o  out  16  error/timeout counter, saturating

Behaviour:
- Reset (async assert, sync deassert by design convention): every output 0, state IDLE, rr pointer = N_CORES (so ctrl has first priority), timeout counter 0, err_count_o 0. Reset mid-transfer abandons the downstream cycle immediately; cyc/stb drop asynchronously.
- A requester is requesting when cyc & stb.
- FSM IDLE:
  - Sample requests each cycle.
  - If any is requesting, grant the first index after the rr pointer, searching upward mod N_CORES+1.
  - Register adr/sel/we/dat for the winner. Cores always drive sel=4'hF, we=0, dat=0.
  - Set m_wb_cyc_o = m_wb_stb_o = 1, set grant_o, update rr pointer to the winner, go to BUS.
  - Request sampled in cycle N gives cyc/stb high in cycle N+1.
- FSM BUS:
  - Hold all m_wb_* outputs stable. Timeout counter increments each cycle.
  - On m_wb_ack_i at cycle M: drop cyc/stb at M+1, register m_wb_dat_i into ctrl_wb_dat_o or c_wb_dat_o, pulse the owner's ack for exactly cycle M+1, go to RESP.
  - On m_wb_err_i (err has priority over a simultaneous ack), or when the counter reaches TIMEOUT with TIMEOUT≠0: same as ack, except read data = 32'h0 and err_count_o += 1, saturating at 16'hFFFF.
- FSM RESP:
  - One cycle; owner ack high, grant_o still set.
  - Requests are ignored. Go to IDLE; grant_o cleared.
  - Minimum gap between downstream transfers is 2 cycles with cyc low (RESP + IDLE).
- If the requester drops stb during BUS, the transfer still completes and its ack pulse is emitted; the requester must ignore it.
- A ctrl requester that holds cyc across several transfers is re-arbitrated per transfer; no bus locking.
- Non-owner ack outputs are always 0. Read data holds its last value until the next completion.
- Fairness: with all N_CORES+1 requesting continuously, each is granted exactly once per N_CORES+1 transfers.

Test Plan:
- Post-reset ctrl read of 0x1000, slave acks 2 cycles after stb with 0xCAFEF00D -> m_wb_adr_o=0x1000, we=0; ctrl_wb_ack_o is a single pulse the cycle after m_wb_ack_i; ctrl_wb_dat_o=0xCAFEF00D; c_wb_ack_o stays 0.
- Ctrl and all 4 cores request continuously, zero-wait slave -> grant order ctrl, c0, c1, c2, c3, ctrl, …; exactly 1 grant each per 5 transfers; cyc low ≥2 cycles between transfers.
- Core2 read of 0x2000 answered with m_wb_err_i -> c_wb_ack_o=4'b0100 for 1 cycle, c_wb_dat_o=0, err_count_o=1.
- TIMEOUT=8, slave never acks core0 -> cyc drops 8 cycles after BUS entry, core0 acked with data 0, err_count_o increments, arbiter then serves a pending ctrl request.
- Assert wb_rst_n=0 mid-BUS -> cyc/stb/acks/grant_o go to 0 at once, without waiting for a clock edge; after release, a ctrl request is granted first.
- Force err_count to 0xFFFF, inject one more error -> counter stays 0xFFFF.
